// File: rtl/ofdm_tx_pkg.sv
// Shared types and helpers for the OFDM TX mapper: FSM states, bin classes, carrier counts and QPSK levels.
package ofdm_tx_pkg;

  typedef enum logic {COLLECT, EMIT} state_t;

  typedef enum logic [1:0] {BIN_NULL, BIN_PILOT, BIN_DATA} bin_type_t;

  // Data carriers per symbol: all bins minus DC minus the non-DC pilots.
  function automatic int data_carriers(input int sym_len, input int spacing);
    return sym_len - 1 - (sym_len / spacing - 1);
  endfunction

  function automatic bin_type_t bin_type(input int k, input int spacing);
    if (k == 0) return BIN_NULL;
    if ((k % spacing) == 0) return BIN_PILOT;
    return BIN_DATA;
  endfunction

  // A set sign bit selects the negative constellation level.
  function automatic int qpsk_value(input logic sign_bit, input int amp);
    return sign_bit ? -amp : amp;
  endfunction

endpackage

// File: rtl/ofdm_tx_mapper_if.sv
// Pair input and bin output handshake bundle of the OFDM TX mapper.
interface ofdm_tx_mapper_if #(
  parameter int sample_bit_width_g = 12
);
  logic [1:0]                           tx_data;
  logic                                 tx_data_valid;
  logic                                 tx_data_start;
  logic                                 tx_data_ready;
  logic signed [sample_bit_width_g-1:0] map_i;
  logic signed [sample_bit_width_g-1:0] map_q;
  logic                                 map_valid;
  logic                                 map_start;
  logic                                 map_last;
  logic                                 map_ready;

  modport master (
    output tx_data, tx_data_valid, tx_data_start, map_ready,
    input  tx_data_ready, map_i, map_q, map_valid, map_start, map_last
  );

  modport slave (
    input  tx_data, tx_data_valid, tx_data_start, map_ready,
    output tx_data_ready, map_i, map_q, map_valid, map_start, map_last
  );
endinterface

// File: rtl/ofdm_tx_carrier_sel.sv
// Bin counter for the symbol being emitted: classifies the next bin and tracks the data buffer read index.
// Advances one bin per load; clear returns both counters to the start of a symbol.
module ofdm_tx_carrier_sel
  import ofdm_tx_pkg::*;
#(
  parameter int symbol_length_g = 64,
  parameter int pilot_spacing_g = 8,
  parameter int data_width_g    = 6
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               clear,
  input  logic                               advance,
  output logic [$clog2(symbol_length_g)-1:0] bin_k,
  output bin_type_t                          bin_typ,
  output logic                               bin_last,
  output logic [data_width_g-1:0]            rd_idx
);
  localparam int KW = $clog2(symbol_length_g);
  localparam logic [KW-1:0] K_LAST = KW'(symbol_length_g - 1);

  assign bin_typ  = bin_type(int'(bin_k), pilot_spacing_g);
  assign bin_last = (bin_k == K_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      bin_k  <= '0;
      rd_idx <= '0;
    end else if (advance) begin
      bin_k <= bin_k + 1'b1;
      if (bin_typ == BIN_DATA) rd_idx <= rd_idx + 1'b1;
    end
  end
endmodule

// File: rtl/ofdm_tx_mapper.sv
// OFDM TX mapper: gathers one symbol of QPSK pairs, then emits every FFT bin (null DC, pilots, data) as signed I/Q.
// First bin one cycle after the last pair; input stalled while emitting, bin outputs held while map_ready is low.
module ofdm_tx_mapper
  import ofdm_tx_pkg::*;
#(
  parameter int sample_bit_width_g = 12,
  parameter int symbol_length_g    = 64,
  parameter int pilot_spacing_g    = 8,
  parameter int amplitude_g        = 1024
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            sys_init,
  ofdm_tx_mapper_if.slave bus
);
  localparam int D  = data_carriers(symbol_length_g, pilot_spacing_g);
  localparam int DW = $clog2(D);
  localparam int KW = $clog2(symbol_length_g);
  localparam logic [DW-1:0] WR_LAST = DW'(D - 1);

  state_t                               state;
  logic [DW-1:0]                        wr_cnt;
  logic [DW-1:0]                        rd_idx;
  logic [KW-1:0]                        bin_k;
  bin_type_t                            bin_typ;
  logic                                 bin_last;
  logic [1:0]                           buf_q [D];
  logic [1:0]                           rd_pair;
  logic signed [sample_bit_width_g-1:0] nxt_i;
  logic signed [sample_bit_width_g-1:0] nxt_q;
  logic                                 xfer_in;
  logic                                 xfer_out;
  logic                                 enter_emit;
  logic                                 emit_done;
  logic                                 load_bin;

  assign xfer_in    = (state == COLLECT) && bus.tx_data_valid && bus.tx_data_ready;
  assign xfer_out   = (state == EMIT) && bus.map_valid && bus.map_ready;
  assign enter_emit = xfer_in && !bus.tx_data_start && (wr_cnt == WR_LAST);
  assign emit_done  = xfer_out && bus.map_last;
  // Output registers always hold the current bin; the next one is loaded as it is accepted.
  assign load_bin   = enter_emit || (xfer_out && !bus.map_last);

  ofdm_tx_carrier_sel #(
    .symbol_length_g (symbol_length_g),
    .pilot_spacing_g (pilot_spacing_g),
    .data_width_g    (DW)
  ) u_carrier_sel (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clear    (sys_init || emit_done),
    .advance  (load_bin),
    .bin_k    (bin_k),
    .bin_typ  (bin_typ),
    .bin_last (bin_last),
    .rd_idx   (rd_idx)
  );

  assign rd_pair = buf_q[rd_idx];

  always_comb begin
    nxt_i = '0;
    nxt_q = '0;
    case (bin_typ)
      BIN_PILOT: nxt_i = sample_bit_width_g'(amplitude_g);
      BIN_DATA: begin
        nxt_i = sample_bit_width_g'(qpsk_value(rd_pair[0], amplitude_g));
        nxt_q = sample_bit_width_g'(qpsk_value(rd_pair[1], amplitude_g));
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (xfer_in) buf_q[bus.tx_data_start ? '0 : wr_cnt] <= bus.tx_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || sys_init) begin
      state             <= COLLECT;
      wr_cnt            <= '0;
      bus.tx_data_ready <= 1'b0;
      bus.map_valid     <= 1'b0;
      bus.map_start     <= 1'b0;
      bus.map_last      <= 1'b0;
      bus.map_i         <= '0;
      bus.map_q         <= '0;
    end else begin
      case (state)
        COLLECT: begin
          bus.tx_data_ready <= 1'b1;
          if (xfer_in) begin
            if (bus.tx_data_start) begin
              wr_cnt <= DW'(1);
            end else if (wr_cnt == WR_LAST) begin
              wr_cnt            <= '0;
              state             <= EMIT;
              bus.tx_data_ready <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (emit_done) begin
            state             <= COLLECT;
            bus.tx_data_ready <= 1'b1;
            bus.map_valid     <= 1'b0;
            bus.map_start     <= 1'b0;
            bus.map_last      <= 1'b0;
          end
        end
      endcase
      if (load_bin) begin
        bus.map_valid <= 1'b1;
        bus.map_i     <= nxt_i;
        bus.map_q     <= nxt_q;
        bus.map_start <= (bin_k == '0);
        bus.map_last  <= bin_last;
      end
    end
  end
endmodule

// File: tb/tb_ofdm_tx_mapper.sv
// Scoreboard bench for ofdm_tx_mapper: stimulus queues expected bins, a negedge monitor pops and compares.
module tb_ofdm_tx_mapper;
  localparam int SL = 64;
  localparam int PS = 8;
  localparam int D  = 56;
  localparam logic signed [11:0] AMP = 12'sd1024;

  typedef struct packed {
    logic signed [11:0] i;
    logic signed [11:0] q;
    logic               s;
    logic               l;
  } bin_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b0;
  int   cyc = 0;

  ofdm_tx_mapper_if #(.sample_bit_width_g(12)) bus ();

  ofdm_tx_mapper #(
    .sample_bit_width_g (12),
    .symbol_length_g    (SL),
    .pilot_spacing_g    (PS),
    .amplitude_g        (1024)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .sys_init (init),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  bin_t       exp_q[$];
  logic [1:0] model[$];
  bin_t       bin1_log[$];
  int         acc_cyc = 0;
  int         last_bin_cyc = 0;
  int         exp_span = SL - 1;
  bit         toggle = 0;

  task automatic check(input bit ok, input string name, input string act, input string req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  function automatic string fmt(input bin_t b);
    return $sformatf("(%0d,%0d) s%0b l%0b", b.i, b.q, b.s, b.l);
  endfunction

  task automatic push_symbol();
    int j = 0;
    bin_t b;
    logic [1:0] d;
    for (int k = 0; k < SL; k++) begin
      b.s = (k == 0);
      b.l = (k == SL - 1);
      if (k == 0) begin
        b.i = 0; b.q = 0;
      end else if ((k % PS) == 0) begin
        b.i = AMP; b.q = 0;
      end else begin
        d = model[j];
        j++;
        b.i = d[0] ? -AMP : AMP;
        b.q = d[1] ? -AMP : AMP;
      end
      exp_q.push_back(b);
    end
    model.delete();
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the pair is accepted.
  task automatic put(input logic [1:0] d, input logic s);
    int waited = 0;
    bus.tx_data = d;
    bus.tx_data_start = s;
    bus.tx_data_valid = 1'b1;
    @(negedge clk);
    while (!bus.tx_data_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    check(bus.tx_data_ready, "put_accept", "timeout", "tx_data_ready");
    if (bus.tx_data_ready) begin
      acc_cyc = cyc;
      if (s) model.delete();
      model.push_back(d);
      if (model.size() == D) push_symbol();
    end else begin
      bus.tx_data_valid = 1'b0;
    end
    sync();
  endtask

  task automatic chk_first_bin(input string name);
    bus.tx_data_valid = 1'b0;
    bus.tx_data_start = 1'b0;
    @(negedge clk);
    check(bus.map_valid && bus.map_start && !bus.tx_data_ready && cyc == acc_cyc + 1, name,
          $sformatf("v%0b s%0b r%0b cyc%0d", bus.map_valid, bus.map_start, bus.tx_data_ready, cyc),
          $sformatf("v1 s1 r0 cyc%0d", acc_cyc + 1));
    sync();
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.tx_data_valid = 1'b0;
    while ((exp_q.size() != 0 || !bus.tx_data_ready) && n < 600) begin
      n++;
      @(negedge clk);
    end
    check(exp_q.size() == 0, name, $sformatf("%0d bins left", exp_q.size()), "0 bins left");
    sync();
  endtask

  // Monitor
  bin_t cur, held, e;
  bit   hold_chk = 0;
  bit   rdy_chk = 0;
  int   rdy_chk_cyc = 0;
  int   mon_k = 0;
  int   idx = 0;
  int   t0 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      cur = {bus.map_i, bus.map_q, bus.map_start, bus.map_last};
      if (rdy_chk && cyc == rdy_chk_cyc) begin
        check(bus.tx_data_ready, "ready_after_last", $sformatf("%0b", bus.tx_data_ready), "1");
        rdy_chk = 0;
      end
      if (hold_chk) begin
        check(bus.map_valid && cur == held, "hold_stable",
              $sformatf("v%0b %s", bus.map_valid, fmt(cur)), $sformatf("v1 %s", fmt(held)));
        hold_chk = 0;
      end
      if (bus.map_valid) begin
        check(!bus.tx_data_ready, "no_overlap", "tx_data_ready=1", "tx_data_ready=0");
        if (bus.map_ready) begin
          idx = bus.map_start ? 0 : mon_k;
          check(exp_q.size() != 0, "unexpected_bin", fmt(cur), "no bin");
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(cur == e, $sformatf("bin%0d", idx), fmt(cur), fmt(e));
          end
          if (idx == 1) bin1_log.push_back(cur);
          if (bus.map_start) t0 = cyc;
          if (bus.map_last) begin
            check(cyc - t0 == exp_span, "emit_span", $sformatf("%0d", cyc - t0),
                  $sformatf("%0d", exp_span));
            last_bin_cyc = cyc;
            rdy_chk = 1;
            rdy_chk_cyc = cyc + 1;
          end
          mon_k = idx + 1;
        end else begin
          held = cur;
          hold_chk = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.map_ready = toggle ? ~bus.map_ready : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_data = 2'b00;
    bus.tx_data_valid = 1'b0;
    bus.tx_data_start = 1'b0;
    bus.map_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then ready rises one cycle later
    @(negedge clk);
    check({bus.tx_data_ready, bus.map_valid, bus.map_start, bus.map_last} == 4'b0000
          && bus.map_i == 0 && bus.map_q == 0, "reset_outputs",
          $sformatf("r%0b v%0b s%0b l%0b i%0d q%0d", bus.tx_data_ready, bus.map_valid,
                    bus.map_start, bus.map_last, bus.map_i, bus.map_q), "all zero");
    @(negedge clk);
    check(bus.tx_data_ready, "ready_after_reset", $sformatf("%0b", bus.tx_data_ready), "1");
    sync();

    // All-zero pairs: pilots and positive data bins
    for (int i = 0; i < 2 * D; i++) put(2'b00, 1'b0);
    chk_first_bin("zero_first_bin_latency");
    drain("zero_drain");

    // Counting pairs cycle through all four constellation points
    for (int i = 0; i < 2 * D; i++) put(2'(i % 4), 1'b0);
    chk_first_bin("count_first_bin_latency");
    drain("count_drain");

    // Toggling map_ready stretches each symbol to 126 cycles between first and last transfer
    toggle = 1;
    exp_span = 2 * (SL - 1);
    for (int i = 0; i < 2 * D; i++) put(2'((3 * i) % 4), 1'b0);
    drain("toggle_drain");
    toggle = 0;
    exp_span = SL - 1;
    sync();

    // A start pair discards the 30 earlier pairs
    bin1_log.delete();
    for (int i = 0; i < 30; i++) put(2'b01, 1'b0);
    put(2'b11, 1'b1);
    for (int i = 0; i < 2 * D - 1; i++) put(2'(i % 4), 1'b0);
    chk_first_bin("restart_first_bin_latency");
    drain("restart_drain");
    check(bin1_log.size() > 0 && bin1_log[0].i == -AMP && bin1_log[0].q == -AMP,
          "restart_first_data", bin1_log.size() > 0 ? fmt(bin1_log[0]) : "none", "(-1024,-1024)");

    // Soft clear while bin 20 is presented aborts the symbol
    for (int i = 0; i < 2 * D; i++) put(2'((i + 1) % 4), 1'b0);
    chk_first_bin("init_first_bin_latency");
    repeat (19) @(posedge clk);
    #1 init = 1'b1;
    sync();
    init = 1'b0;
    @(negedge clk);
    check(!bus.map_valid && !bus.tx_data_ready, "init_abort",
          $sformatf("v%0b r%0b", bus.map_valid, bus.tx_data_ready), "v0 r0");
    exp_q.delete();
    model.delete();
    @(negedge clk);
    check(bus.tx_data_ready && !bus.map_valid, "init_ready",
          $sformatf("r%0b v%0b", bus.tx_data_ready, bus.map_valid), "r1 v0");
    sync();
    for (int i = 0; i < 2 * D; i++) put(2'((i + 2) % 4), 1'b0);
    chk_first_bin("post_init_first_bin_latency");
    drain("post_init_drain");

    // Valid held through EMIT: the waiting pair is taken only after return to COLLECT
    bin1_log.delete();
    for (int i = 0; i < D; i++) put(2'b00, 1'b0);
    put(2'b11, 1'b0);
    check(acc_cyc == last_bin_cyc + 1, "held_valid_accept_cycle", $sformatf("%0d", acc_cyc),
          $sformatf("%0d", last_bin_cyc + 1));
    for (int i = 0; i < D - 1; i++) put(2'(i % 4), 1'b0);
    chk_first_bin("held_first_bin_latency");
    drain("held_drain");
    check(bin1_log.size() == 2 && bin1_log[1].i == -AMP && bin1_log[1].q == -AMP,
          "held_first_data", bin1_log.size() == 2 ? fmt(bin1_log[1]) : "missing", "(-1024,-1024)");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
